// File: rtl/ixc_sv_gfifo_pkg.sv
// Shared types and helpers for the SV global FIFO producer.
package ixc_sv_gfifo_pkg;

  typedef logic [63:0] cnt_t;

  typedef enum logic [1:0] {IDLE, ARMED, NOTIFY} notify_state_e;

  // Free slots seen by the producer; modular so wrapped counts stay correct.
  function automatic cnt_t space_f(cnt_t pend, cnt_t rd, int depth);
    return cnt_t'(depth) - (pend - rd);
  endfunction

endpackage

// File: rtl/ixc_sv_gfifo_notify_fsm.sv
// Host notification: arms on commit, fires on flush timeout or high watermark.
module ixc_sv_gfifo_notify_fsm
  import ixc_sv_gfifo_pkg::*;
#(
  parameter int LW        = 9,
  parameter int HIGH_WM   = 192,
  parameter int FLUSH_TMO = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          commit,
  input  logic [LW-1:0] level,
  input  logic          notify_ack,
  output logic          notify
);

  localparam logic [LW-1:0] HWM      = LW'(HIGH_WM);
  localparam logic [15:0]   TMO_LAST = 16'(FLUSH_TMO - 1);

  notify_state_e state, stateNxt;
  logic [15:0]   timer, timerNxt;
  logic          seen, seenNxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      timer <= '0;
      seen  <= 1'b0;
    end else begin
      state <= stateNxt;
      timer <= timerNxt;
      seen  <= seenNxt;
    end
  end

  always_comb begin
    stateNxt = state;
    timerNxt = timer;
    seenNxt  = seen;
    case (state)
      IDLE: if (commit) begin
        stateNxt = ARMED;
        timerNxt = '0;
      end
      ARMED: begin
        timerNxt = commit ? '0 : timer + 16'd1;
        if (timer == TMO_LAST || level >= HWM) begin
          stateNxt = NOTIFY;
          timerNxt = '0;
          seenNxt  = 1'b0;
        end else if (level == '0) begin
          stateNxt = IDLE;
          timerNxt = '0;
        end
      end
      NOTIFY: begin
        // A commit while notifying must re-arm, otherwise it could sit unflushed.
        if (commit) seenNxt = 1'b1;
        if (notify_ack) begin
          stateNxt = (seen || commit) ? ARMED : IDLE;
          timerNxt = '0;
          seenNxt  = 1'b0;
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  assign notify = (state == NOTIFY);

endmodule

// File: rtl/ixc_sv_gfifo_writer.sv
// Producer end of the SV global FIFO: writes record words, commits whole records,
// tracks occupancy against the host read count and raises notify.
module ixc_sv_gfifo_writer
  import ixc_sv_gfifo_pkg::*;
#(
  parameter int   DEPTH     = 256,
  parameter int   WIDTH     = 64,
  parameter int   HIGH_WM   = 192,
  parameter int   FLUSH_TMO = 16,
  parameter cnt_t CNT_RST   = '0   // count reset value; nonzero only for wrap testing
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_last,
  input  cnt_t                     rd_cnt,
  output logic                     mem_we,
  output logic [$clog2(DEPTH)-1:0] mem_addr,
  output logic [WIDTH-1:0]         mem_wdata,
  output cnt_t                     wr_cnt,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     notify,
  input  logic                     notify_ack,
  output logic                     ovf_err,
  output logic                     rd_err
);

  localparam int AW = $clog2(DEPTH);

  cnt_t        pendCnt, wrCnt, wrNext, rdDiff;
  logic        run, drop, ovfErr, rdErr, hs, commit, ovfHit, rdAhead;
  logic [AW:0] levelQ;

  // run keeps in_ready low while reset is asserted.
  assign in_ready  = run & (drop | (space_f(pendCnt, rd_cnt, DEPTH) != '0));
  assign hs        = in_valid & in_ready;
  assign mem_we    = hs & ~drop;
  assign mem_addr  = pendCnt[AW-1:0];
  assign mem_wdata = mem_we ? in_data : '0;
  assign commit    = mem_we & in_last;
  assign ovfHit    = mem_we & ~in_last & ((pendCnt - wrCnt) == cnt_t'(DEPTH - 1));
  assign wrNext    = commit ? pendCnt + 64'd1 : wrCnt;
  assign rdDiff    = rd_cnt - wrNext;
  assign rdAhead   = (rdDiff != '0) & ~rdDiff[63];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run     <= 1'b0;
      pendCnt <= CNT_RST;
      wrCnt   <= CNT_RST;
      drop    <= 1'b0;
      ovfErr  <= 1'b0;
      rdErr   <= 1'b0;
      levelQ  <= '0;
    end else begin
      run   <= 1'b1;
      wrCnt <= wrNext;
      if (ovfHit)      pendCnt <= wrCnt;
      else if (mem_we) pendCnt <= pendCnt + 64'd1;
      if (ovfHit)                    drop <= 1'b1;
      else if (hs && drop && in_last) drop <= 1'b0;
      if (ovfHit) ovfErr <= 1'b1;
      if (rdAhead) rdErr  <= 1'b1;
      else         levelQ <= wrNext[AW:0] - rd_cnt[AW:0];
    end
  end

  assign wr_cnt  = wrCnt;
  assign level   = levelQ;
  assign ovf_err = ovfErr;
  assign rd_err  = rdErr;

  ixc_sv_gfifo_notify_fsm #(
    .LW        (AW + 1),
    .HIGH_WM   (HIGH_WM),
    .FLUSH_TMO (FLUSH_TMO)
  ) uNotify (
    .clk        (clk),
    .rst_n      (rst_n),
    .commit     (commit),
    .level      (levelQ),
    .notify_ack (notify_ack),
    .notify     (notify)
  );

endmodule

// File: tb/tb_ixc_sv_gfifo_writer.sv
// Directed bench for ixc_sv_gfifo_writer; a second instance starts near count wrap.
module tb_ixc_sv_gfifo_writer;
  import ixc_sv_gfifo_pkg::*;

  localparam cnt_t WRAP0 = 64'hFFFF_FFFF_FFFF_FFFC;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, in_last = 1'b0, notify_ack = 1'b0, in_validW = 1'b0;
  logic [63:0] in_data = '0;
  cnt_t        rd_cnt = '0, rd_cntW = WRAP0;

  logic        in_ready, mem_we, notify, ovf_err, rd_err;
  logic [7:0]  mem_addr;
  logic [63:0] mem_wdata;
  cnt_t        wr_cnt;
  logic [8:0]  level;

  logic        in_readyW, mem_weW, notifyW, ovf_errW, rd_errW;
  logic [7:0]  mem_addrW;
  logic [63:0] mem_wdataW;
  cnt_t        wr_cntW;
  logic [8:0]  levelW;

  int nChk = 0, nFail = 0;

  always #5 clk = ~clk;

  ixc_sv_gfifo_writer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .rd_cnt(rd_cnt), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .wr_cnt(wr_cnt), .level(level),
    .notify(notify), .notify_ack(notify_ack), .ovf_err(ovf_err), .rd_err(rd_err)
  );

  ixc_sv_gfifo_writer #(.CNT_RST(WRAP0)) dutW (
    .clk(clk), .rst_n(rst_n), .in_valid(in_validW), .in_ready(in_readyW),
    .in_data(in_data), .in_last(in_last), .rd_cnt(rd_cntW), .mem_we(mem_weW),
    .mem_addr(mem_addrW), .mem_wdata(mem_wdataW), .wr_cnt(wr_cntW), .level(levelW),
    .notify(notifyW), .notify_ack(notify_ack), .ovf_err(ovf_errW), .rd_err(rd_errW)
  );

  task automatic doReset();
    in_valid = 0; in_validW = 0; in_last = 0; in_data = '0; notify_ack = 0; rd_cnt = '0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [63:0] d, input logic l);
    int t = 0;
    in_valid = 1; in_data = d; in_last = l; #1;
    while (!in_ready && t < 1000) begin @(posedge clk); #1; t++; end
    if (!in_ready) begin
      nChk++; nFail++;
      $display("FAIL push_timeout: in_ready=%b after %0d cycles, want 1", in_ready, t);
    end
    @(posedge clk); #1;
    in_valid = 0; in_last = 0;
  endtask

  task automatic test_reset();
    in_valid = 0; in_data = 64'hDEAD; rst_n = 0; #1;
    nChk++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, wr_cnt, level, notify, ovf_err, rd_err} !== '0) begin
      nFail++;
      $display("FAIL reset_outputs: rdy=%b we=%b addr=%0d wdata=%h wr=%0d lvl=%0d ntf=%b ovf=%b rde=%b, want all 0",
               in_ready, mem_we, mem_addr, mem_wdata, wr_cnt, level, notify, ovf_err, rd_err);
    end
    doReset();
    nChk++;
    if (in_ready !== 1'b1) begin nFail++; $display("FAIL reset_ready: in_ready=%b, want 1", in_ready); end
  endtask

  task automatic test_records();
    doReset();
    for (int r = 0; r < 10; r++) begin
      for (int w = 0; w < 3; w++) begin
        in_valid = 1; in_data = 64'(100 + r*3 + w); in_last = (w == 2); #1;
        nChk++;
        if (mem_we !== 1'b1 || mem_addr !== 8'(r*3 + w) || mem_wdata !== 64'(100 + r*3 + w)) begin
          nFail++;
          $display("FAIL rec_write r=%0d w=%0d: we=%b addr=%0d data=%0d, want we=1 addr=%0d data=%0d",
                   r, w, mem_we, mem_addr, mem_wdata, r*3 + w, 100 + r*3 + w);
        end
        @(posedge clk); #1;
        nChk++;
        if (wr_cnt !== 64'((w == 2) ? 3*(r+1) : 3*r)) begin
          nFail++;
          $display("FAIL rec_wrcnt r=%0d w=%0d: wr_cnt=%0d, want %0d", r, w, wr_cnt, (w == 2) ? 3*(r+1) : 3*r);
        end
      end
    end
    in_valid = 0; in_last = 0;
    @(posedge clk); #1;
    nChk++;
    if (level !== 9'd30) begin nFail++; $display("FAIL rec_level: level=%0d, want 30", level); end
  endtask

  task automatic test_gap();
    int bad = 0;
    doReset();
    push(64'h11, 0);
    if (wr_cnt !== 64'd0) bad++;
    push(64'h12, 0);
    if (wr_cnt !== 64'd0) bad++;
    repeat (3) begin @(posedge clk); #1; if (wr_cnt !== 64'd0) bad++; end
    push(64'h13, 0);
    if (wr_cnt !== 64'd0) bad++;
    nChk++;
    if (bad != 0) begin nFail++; $display("FAIL gap_partial: %0d cycles showed wr_cnt!=0, want 0", bad); end
    push(64'h14, 1);
    nChk++;
    if (wr_cnt !== 64'd4 || level !== 9'd4) begin
      nFail++; $display("FAIL gap_commit: wr_cnt=%0d level=%0d, want 4 4", wr_cnt, level);
    end
  endtask

  task automatic test_full();
    doReset();
    in_valid = 1; in_last = 1;
    for (int i = 0; i < 256; i++) begin in_data = 64'(i); @(posedge clk); #1; end
    nChk++;
    if (in_ready !== 1'b0 || wr_cnt !== 64'd256) begin
      nFail++; $display("FAIL full_stop: in_ready=%b wr_cnt=%0d, want 0 256", in_ready, wr_cnt);
    end
    repeat (3) @(posedge clk); #1;
    nChk++;
    if (mem_we !== 1'b0 || wr_cnt !== 64'd256) begin
      nFail++; $display("FAIL full_hold: mem_we=%b wr_cnt=%0d, want 0 256", mem_we, wr_cnt);
    end
    rd_cnt = 64'd10;
    for (int k = 0; k < 10; k++) begin
      in_data = 64'(500 + k); #1;
      nChk++;
      if (mem_we !== 1'b1 || mem_addr !== 8'(k)) begin
        nFail++; $display("FAIL full_wrap k=%0d: we=%b addr=%0d, want 1 %0d", k, mem_we, mem_addr, k);
      end
      @(posedge clk); #1;
    end
    nChk++;
    if (in_ready !== 1'b0 || wr_cnt !== 64'd266 || level !== 9'd256) begin
      nFail++; $display("FAIL full_refill: in_ready=%b wr_cnt=%0d level=%0d, want 0 266 256", in_ready, wr_cnt, level);
    end
    in_valid = 0; in_last = 0;
  endtask

  task automatic test_oversize();
    int bad = 0;
    doReset();
    push(64'h1, 0);
    push(64'h2, 1);
    rd_cnt = 64'd2;
    in_valid = 1;
    for (int i = 1; i <= 300; i++) begin
      in_data = 64'(i); in_last = (i == 300); #1;
      if (i <= 256 && mem_we !== 1'b1) bad++;
      if (i > 256 && (mem_we !== 1'b0 || in_ready !== 1'b1)) bad++;
      if (i == 256) begin
        nChk++;
        if (ovf_err !== 1'b0) begin nFail++; $display("FAIL ovf_early: ovf_err=%b before word 256, want 0", ovf_err); end
      end
      @(posedge clk); #1;
      if (i == 256) begin
        nChk++;
        if (ovf_err !== 1'b1) begin nFail++; $display("FAIL ovf_set: ovf_err=%b after word 256, want 1", ovf_err); end
      end
    end
    in_valid = 0; in_last = 0;
    nChk++;
    if (bad != 0 || wr_cnt !== 64'd2) begin
      nFail++; $display("FAIL ovf_swallow: bad=%0d wr_cnt=%0d, want 0 2", bad, wr_cnt);
    end
    in_valid = 1; in_data = 64'h77; #1;
    nChk++;
    if (mem_we !== 1'b1 || mem_addr !== 8'd2) begin
      nFail++; $display("FAIL ovf_rewind: we=%b addr=%0d, want 1 2", mem_we, mem_addr);
    end
    @(posedge clk); #1;
    in_last = 1;
    @(posedge clk); #1;
    in_valid = 0; in_last = 0;
    nChk++;
    if (wr_cnt !== 64'd4 || ovf_err !== 1'b1) begin
      nFail++; $display("FAIL ovf_next: wr_cnt=%0d ovf_err=%b, want 4 1", wr_cnt, ovf_err);
    end
  endtask

  task automatic test_notify();
    int cnt;
    doReset();
    push(64'h5, 1);
    cnt = 0;
    while (!notify && cnt < 100) begin
      notify_ack = (cnt == 5);   // outside NOTIFY, must have no effect
      @(posedge clk); #1; cnt++;
    end
    notify_ack = 0;
    nChk++;
    if (cnt != 16) begin nFail++; $display("FAIL ntf_timeout: notify after %0d cycles, want 16", cnt); end
    push(64'h6, 1);
    repeat (2) @(posedge clk); #1;
    nChk++;
    if (notify !== 1'b1) begin nFail++; $display("FAIL ntf_hold: notify=%b, want 1", notify); end
    notify_ack = 1; @(posedge clk); #1; notify_ack = 0;
    nChk++;
    if (notify !== 1'b0) begin nFail++; $display("FAIL ntf_ack: notify=%b, want 0", notify); end
    cnt = 0;
    while (!notify && cnt < 100) begin @(posedge clk); #1; cnt++; end
    nChk++;
    if (cnt != 16) begin nFail++; $display("FAIL ntf_rearm: notify after %0d cycles, want 16", cnt); end
    notify_ack = 1; @(posedge clk); #1; notify_ack = 0;
    repeat (20) @(posedge clk); #1;
    nChk++;
    if (notify !== 1'b0) begin nFail++; $display("FAIL ntf_idle: notify=%b, want 0", notify); end
  endtask

  task automatic test_wrap();
    doReset();
    nChk++;
    if (wr_cntW !== WRAP0) begin nFail++; $display("FAIL wrap_start: wr_cnt=%h, want %h", wr_cntW, WRAP0); end
    in_validW = 1;
    for (int k = 0; k < 8; k++) begin
      in_data = 64'(k); in_last = (k == 7); #1;
      nChk++;
      if (mem_weW !== 1'b1 || mem_addrW !== 8'(252 + k)) begin
        nFail++; $display("FAIL wrap_addr k=%0d: we=%b addr=%0d, want 1 %0d", k, mem_weW, mem_addrW, (252 + k) % 256);
      end
      @(posedge clk); #1;
    end
    in_validW = 0; in_last = 0;
    nChk++;
    if (wr_cntW !== 64'd4 || levelW !== 9'd8) begin
      nFail++; $display("FAIL wrap_end: wr_cnt=%0d level=%0d, want 4 8", wr_cntW, levelW);
    end
  endtask

  task automatic test_rd_err_and_reset();
    doReset();
    push(64'hA, 0);
    push(64'hB, 1);
    rd_cnt = 64'd3;
    @(posedge clk); #1;
    nChk++;
    if (rd_err !== 1'b1 || level !== 9'd2) begin
      nFail++; $display("FAIL rderr: rd_err=%b level=%0d, want 1 2", rd_err, level);
    end
    rd_cnt = 64'd2;
    push(64'hC, 0);
    push(64'hD, 0);
    rst_n = 0; rd_cnt = '0; #1;
    nChk++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, wr_cnt, level, notify, ovf_err, rd_err} !== '0) begin
      nFail++;
      $display("FAIL midrec_reset: rdy=%b we=%b addr=%0d wr=%0d lvl=%0d ntf=%b ovf=%b rde=%b, want all 0",
               in_ready, mem_we, mem_addr, wr_cnt, level, notify, ovf_err, rd_err);
    end
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    nChk++;
    if (in_ready !== 1'b1 || wr_cnt !== 64'd0 || mem_addr !== 8'd0 || rd_err !== 1'b0) begin
      nFail++; $display("FAIL midrec_resume: rdy=%b wr=%0d addr=%0d rde=%b, want 1 0 0 0", in_ready, wr_cnt, mem_addr, rd_err);
    end
  endtask

  initial begin
    test_reset();
    test_records();
    test_gap();
    test_full();
    test_oversize();
    test_notify();
    test_wrap();
    test_rd_err_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
